// File: rtl/demux_1x256_collector.sv
// Bit-serial to word collector: each accepted bit lands at an addressed or
// auto-incremented position, and the word is offered once every position is written.
module demux_1x256_collector #(
  parameter int N     = 256,
  parameter int SEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               din,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       a_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   ptr,
  output logic [SEL_W:0]     fill_cnt
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     mask;
  logic [SEL_W-1:0] idx;
  logic             accept;
  logic             new_pos;
  logic             fill_done;
  logic             release_word;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    idx          = mode ? ptr : sel;
    accept       = in_valid && (state == COLLECT);
    new_pos      = accept && !mask[idx];
    fill_done    = new_pos && (fill_cnt == (SEL_W+1)'(N - 1));
    release_word = (state == HOLD) && out_ready;
    state_nxt    = state;
    case (state)
      COLLECT: if (fill_done)    state_nxt = HOLD;
      HOLD:    if (release_word) state_nxt = COLLECT;
      default:                   state_nxt = COLLECT;
    endcase
    if (clear) state_nxt = COLLECT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // NOTE: the word and the written mask are flops, not a RAM, and must start
  // from a known empty state, so they are reset like any control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out    <= '0;
      mask     <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
    end else if (clear) begin
      a_out    <= '0;
      mask     <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
    end else if (release_word) begin
      // a_out is kept: unwritten bits of the next word inherit this word's values
      mask     <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      a_out[idx] <= din;
      if (new_pos) begin
        mask[idx] <= 1'b1;
        fill_cnt  <= fill_cnt + (SEL_W+1)'(1);
      end
      if (mode) ptr <= ptr + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1x256_collector.sv
// Directed bench for demux_1x256_collector; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_demux_1x256_collector;

  localparam int N     = 256;
  localparam int SEL_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             din;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_out;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W:0]   fill_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] pat;
  logic [N-1:0] word_snap;

  always #5 clk = ~clk;

  demux_1x256_collector #(.N(N), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .sel(sel),
    .din(din), .in_valid(in_valid), .in_ready(in_ready), .a_out(a_out),
    .out_valid(out_valid), .out_ready(out_ready), .ptr(ptr), .fill_cnt(fill_cnt)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one beat for exactly one rising edge, then idles the input.
  task automatic beat(input logic m, input logic [SEL_W-1:0] s, input logic d);
    mode = m; sel = s; din = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; sel = '0; din = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_a_out",     a_out,     '0);
    check("rst_fill",      N'(fill_cnt), '0);
    check("rst_ptr",       N'(ptr),   '0);
    check("rst_out_valid", N'(out_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", N'(in_ready), N'(1));

    // Sequential fill with 0xA3
    pat = N'(8'hA3);
    for (int i = 0; i < N; i++) begin
      beat(1'b1, 8'hFF, pat[i]);
      if (i == 99) check("seq_mid_fill", N'(fill_cnt), N'(100));
    end
    check("seq_out_valid", N'(out_valid), N'(1));
    check("seq_a_out",     a_out,     pat);
    check("seq_fill",      N'(fill_cnt), N'(256));
    check("seq_ptr",       N'(ptr),   '0);
    check("seq_in_ready",  N'(in_ready), '0);

    // Backpressure in HOLD: beats must be ignored
    for (int i = 0; i < 10; i++) begin
      beat(1'b0, 8'h00, 1'b0);
      check("hold_in_ready", N'(in_ready), '0);
    end
    check("hold_a_out",     a_out,     pat);
    check("hold_fill",      N'(fill_cnt), N'(256));
    check("hold_out_valid", N'(out_valid), N'(1));

    // Handshake
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", N'(out_valid), '0);
    check("hs_fill",      N'(fill_cnt), '0);
    check("hs_in_ready",  N'(in_ready), N'(1));
    check("hs_a_kept",    a_out,     pat);

    // Addressed overwrite of bit 5
    beat(1'b0, 8'h05, 1'b1);
    check("ovw_first_bit", N'(a_out[5]), N'(1));
    beat(1'b0, 8'h05, 1'b0);
    check("ovw_bit5",      N'(a_out[5]), '0);
    check("ovw_fill",      N'(fill_cnt), N'(1));
    check("ovw_out_valid", N'(out_valid), '0);

    // Addressed fill in reverse order; bit 5 is already marked written
    for (int s = N - 1; s >= 0; s--) begin
      beat(1'b0, SEL_W'(s), s[0]);
      if (s == 1) check("rev_not_yet_valid", N'(out_valid), '0);
    end
    check("rev_out_valid", N'(out_valid), N'(1));
    check("rev_a_out",     a_out,     {128{2'b10}});
    check("rev_ptr",       N'(ptr),   '0);

    // out_ready held high: released the cycle after out_valid rises
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_out_valid", N'(out_valid), '0);
    check("rel_in_ready",  N'(in_ready), N'(1));
    out_ready = 1'b0;

    // Clear mid-fill with a coincident beat
    for (int i = 0; i < 100; i++) beat(1'b1, 8'h00, 1'b1);
    check("clr_pre_ptr", N'(ptr), N'(100));
    clear = 1'b1;
    beat(1'b1, 8'h00, 1'b1);
    clear = 1'b0;
    check("clr_a_out", a_out,     '0);
    check("clr_fill",  N'(fill_cnt), '0);
    check("clr_ptr",   N'(ptr),   '0);
    beat(1'b1, 8'h00, 1'b1);
    check("clr_next_beat", a_out, N'(1));

    // Asynchronous reset between edges
    for (int i = 0; i < 20; i++) beat(1'b1, 8'h00, 1'b1);
    word_snap = a_out;
    check("ar_pre_fill", N'(fill_cnt), N'(21));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_a_out", a_out,     '0);
    check("ar_fill",  N'(fill_cnt), '0);
    check("ar_ptr",   N'(ptr),   '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(1'b1, 8'hAA, 1'b1);
    check("ar_first_pos", a_out,     N'(1));
    check("ar_first_ptr", N'(ptr),   N'(1));
    check("ar_first_fill", N'(fill_cnt), N'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1x256_collector.md
Name: demux_1x256_collector

Overview:
- Inverse of the 256:1 bit mux: accepts a stream of single bits and writes each into a 256-bit output word.
- Each bit goes either to an explicitly selected position or to an auto-incrementing pointer.
- Presents the assembled word with a valid/ready handshake once every position has been written.
- Sits upstream of the 256:1 mux, so the word it builds can be read back through the mux bit by bit.

Parameters:
- N, 256, output word width (number of bit positions).
- SEL_W, 8, select/pointer width; must equal log2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of word, fill state and pointer.
- mode  input  1  0 = addressed (position = sel); 1 = sequential (position = internal pointer).
- sel  input  SEL_W  target bit position in addressed mode; ignored in sequential mode.
- din  input  1  data bit to write.
- in_valid  input  1  din/sel are valid this cycle.
- in_ready  output  1  collector can accept a bit.
- a_out  output  N  assembled word, registered.
- out_valid  output  1  a_out is complete (all N positions written since last flush).
- out_ready  input  1  downstream consumes the complete word.
- ptr  output  SEL_W  current sequential pointer.
- fill_cnt  output  SEL_W+1  number of distinct positions written, 0..N.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_out = 0, written mask = 0, ptr = 0, fill_cnt = 0, out_valid = 0.
  - State goes to COLLECT; in_ready = 1 after deassertion.
  - Reset mid-collection discards all partial data.
- States: COLLECT, HOLD.
- COLLECT:
  - in_ready = 1, out_valid = 0.
  - Accept when in_valid & in_ready. Target idx = mode ? ptr : sel.
  - On accept: a_out[idx] <= din in the same clock edge, so a_out reflects the bit 1 cycle after acceptance.
  - If mask[idx] was 0: set mask[idx] and increment fill_cnt.
  - If mask[idx] was 1: overwrite a_out[idx] only; mask and fill_cnt unchanged.
  - Sequential mode: ptr increments on every accept, wrapping 255 -> 0.
  - Addressed mode: ptr holds its value.
  - mode may change between beats; ptr is not disturbed by addressed writes.
  - When an accept makes fill_cnt reach N, go to HOLD on that edge. out_valid = 1 and in_ready = 0 from the next cycle.
- HOLD:
  - in_ready = 0; in_valid is ignored and no write occurs.
  - out_valid = 1, and a_out is stable until the handshake.
  - On out_valid & out_ready: mask = 0, fill_cnt = 0, ptr = 0, go to COLLECT.
  - a_out keeps its contents, so unwritten bits of the next word retain the previous word's values.
  - out_valid drops the cycle after the handshake; in_ready rises the same cycle.
- No simultaneous accept and handshake is possible, since in_ready = 0 in HOLD. A complete word therefore costs at least N+1 cycles.
- clear (synchronous, highest priority below rst_n):
  - a_out = 0, mask = 0, fill_cnt = 0, ptr = 0, out_valid = 0, state COLLECT.
  - A beat presented in the same cycle as clear is dropped.
  - clear in HOLD discards the pending word without a handshake.
- Outputs are registered; no combinational path from inputs to a_out, out_valid or fill_cnt. in_ready depends on state only.
- Latency: one cycle from accept to a_out update.
- out_ready held high continuously: word released the cycle after out_valid rises.

Test Plan:
- Sequential fill: mode = 1, stream din = bit i of 256'hA3 (1010_0011 in bits 7:0, zeros above) for i = 0..255, out_ready = 0.
  - After 256 accepts: out_valid = 1, a_out = 256'hA3, fill_cnt = 256, ptr = 0, in_ready = 0.
  - Assert out_ready: out_valid drops next cycle and fill_cnt = 0.
- Addressed overwrite: mode = 0, write sel = 8'h05 din = 1, then sel = 8'h05 din = 0.
  - fill_cnt = 1, a_out[5] = 0, out_valid = 0.
- Addressed fill in reverse order: sel = 255 down to 0, din = sel[0].
  - out_valid = 1 after the last beat; a_out = alternating pattern (odd bits = 1); ptr remains 0.
- HOLD backpressure: with out_valid = 1, drive in_valid = 1 with din = 0 at sel = 0 for 10 cycles.
  - in_ready = 0 throughout; a_out unchanged; fill_cnt = 256.
- Clear mid-fill: after 100 sequential beats, assert clear together with in_valid.
  - Next cycle: a_out = 0, fill_cnt = 0, ptr = 0, and the coincident beat is not written.
- Async reset: drop rst_n between clock edges mid-fill.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release, the first sequential beat lands at position 0.
